// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: fetch-side pipeline stage owning the PC and IF/ID register.
// Applies reset, mem freeze, branch flush and load-use hold in priority order.
//
// Ports:
//   clk_i             clock, all state updates on the rising edge
//   rst_i             synchronous active-high reset
//   pc_write_i        0 = hold PC (load-use)
//   stall_i           1 = hold IF/ID (load-use)
//   mem_stall_i       1 = freeze the whole stage (data-cache miss)
//   flush_i           1 = branch taken in ID, redirect and squash
//   branch_target_i   redirect PC, used when flush_i=1
//   instr_i           instruction memory data for pc_o
//   pc_o              current fetch PC
//   if_id_pc_o        PC of the instruction held in IF/ID
//   if_id_instr_o     instruction held in IF/ID
//   if_id_valid_o     1 = IF/ID holds a real instruction
//   hold_state_o      why the last edge held: 0 RUN, 1 LOAD_USE, 2 MEM, 3 FLUSH
//   stall_cycles_o    saturating count of LOAD_USE/MEM edges
//
// Optional feature macro: STALL_COUNT_EN
//   defined   -> stall_cycles_o is a saturating held-edge counter
//   undefined -> stall_cycles_o is tied to zero, no counter is built

module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        stall_i,
    input  logic        mem_stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic [1:0]  hold_state_o,
    output logic [31:0] stall_cycles_o
);

    localparam logic [1:0] HS_RUN      = 2'd0;
    localparam logic [1:0] HS_LOAD_USE = 2'd1;
    localparam logic [1:0] HS_MEM      = 2'd2;
    localparam logic [1:0] HS_FLUSH    = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        pc:    32'h0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    if_id_t      if_id_q;
    if_id_t      if_id_d;
    logic [1:0]  hold_q;
    logic [1:0]  hold_d;

    // One-hot priority selects; each term masks every higher priority.
    logic sel_mem;
    logic sel_flush;
    logic sel_lu;
    logic sel_run;

    // Either half of the load-use pair alone forces a full hold so a
    // mismatched pair can never drop or duplicate an instruction.
    assign sel_mem   = mem_stall_i;
    assign sel_flush = !mem_stall_i && flush_i;
    assign sel_lu    = !mem_stall_i && !flush_i
                    && (stall_i || !pc_write_i);
    assign sel_run   = !mem_stall_i && !flush_i
                    && !stall_i && pc_write_i;

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        hold_d  = hold_q;
        unique case (1'b1)
            sel_mem: begin
                hold_d = HS_MEM;
            end
            sel_flush: begin
                pc_d    = branch_target_i;
                if_id_d = IF_ID_BUBBLE;
                hold_d  = HS_FLUSH;
            end
            sel_lu: begin
                hold_d = HS_LOAD_USE;
            end
            sel_run: begin
                pc_d    = pc_q + 32'd4;
                if_id_d = '{
                    pc:    pc_q,
                    instr: instr_i,
                    valid: 1'b1
                };
                hold_d  = HS_RUN;
            end
            default: begin
                hold_d = hold_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            if_id_q <= IF_ID_BUBBLE;
            hold_q  <= HS_RUN;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            hold_q  <= hold_d;
        end
    end

    assign pc_o          = pc_q;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;
    assign hold_state_o  = hold_q;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic        stall_hit;

    // Flush edges are not stalls and are not counted.
    assign stall_hit = sel_mem || sel_lu;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_hit && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb_if_id_fetch_stage: table-driven bench with an expected-value queue.
// Drives inputs on the falling edge and checks just after the rising edge.

module tb_if_id_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

`ifdef STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        stall;
    logic        mem_stall;
    logic        flush;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [1:0]  hold_state;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    if_id_fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_write_i      (pc_write),
        .stall_i         (stall),
        .mem_stall_i     (mem_stall),
        .flush_i         (flush),
        .branch_target_i (target),
        .instr_i         (instr),
        .pc_o            (pc),
        .if_id_pc_o      (if_id_pc),
        .if_id_instr_o   (if_id_instr),
        .if_id_valid_o   (if_id_valid),
        .hold_state_o    (hold_state),
        .stall_cycles_o  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mem;
        logic        flush;
        logic        stall;
        logic        pw;
        logic [31:0] tgt;
        logic [31:0] instr;
        logic [31:0] e_pc;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_v;
        logic [1:0]  e_hs;
        logic [31:0] e_cnt;
        string       name;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input string       name,
        input logic        r,
        input logic        m,
        input logic        f,
        input logic        s,
        input logic        w,
        input logic [31:0] t,
        input logic [31:0] i,
        input logic [31:0] epc,
        input logic [31:0] eifpc,
        input logic [31:0] einstr,
        input logic        ev,
        input logic [1:0]  ehs,
        input logic [31:0] ecnt
    );
        vec_t v;
        v.name    = name;
        v.rst     = r;
        v.mem     = m;
        v.flush   = f;
        v.stall   = s;
        v.pw      = w;
        v.tgt     = t;
        v.instr   = i;
        v.e_pc    = epc;
        v.e_ifpc  = eifpc;
        v.e_instr = einstr;
        v.e_v     = ev;
        v.e_hs    = ehs;
        v.e_cnt   = ecnt;
        return v;
    endfunction

    task automatic chk(
        input string       what,
        input string       field,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h",
                     what, field, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        mem_stall = v.mem;
        flush     = v.flush;
        stall     = v.stall;
        pc_write  = v.pw;
        target    = v.tgt;
        instr     = v.instr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", v.name);
        end else begin
            vec_t e;
            e = sb.pop_front();
            chk(e.name, "pc", pc, e.e_pc);
            chk(e.name, "ifpc", if_id_pc, e.e_ifpc);
            chk(e.name, "ifinstr", if_id_instr, e.e_instr);
            chk(e.name, "valid", {31'h0, if_id_valid}, {31'h0, e.e_v});
            chk(e.name, "hold", {30'h0, hold_state}, {30'h0, e.e_hs});
            chk(e.name, "cnt", stall_cycles,
                CNT_EN ? e.e_cnt : 32'h0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_stall = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        pc_write  = 1'b1;
        target    = 32'h0;
        instr     = 32'h0;

        //             name      r m f s w  tgt           instr
        //                       pc            ifpc          ifinstr  v hs cnt
        tbl.push_back(mk("rst0", 1,0,0,0,1, 32'h0,        32'hA0,
                         32'h100,      32'h0,        NOP,     0,0,0));
        tbl.push_back(mk("rst1", 1,0,0,0,1, 32'h0,        32'hA0,
                         32'h100,      32'h0,        NOP,     0,0,0));
        tbl.push_back(mk("run0", 0,0,0,0,1, 32'h0,        32'hA0,
                         32'h104,      32'h100,      32'hA0,  1,0,0));
        tbl.push_back(mk("run1", 0,0,0,0,1, 32'h0,        32'hA1,
                         32'h108,      32'h104,      32'hA1,  1,0,0));
        tbl.push_back(mk("lu",   0,0,0,1,0, 32'h0,        32'hA2,
                         32'h108,      32'h104,      32'hA1,  1,1,1));
        tbl.push_back(mk("run2", 0,0,0,0,1, 32'h0,        32'hA2,
                         32'h10C,      32'h108,      32'hA2,  1,0,1));
        tbl.push_back(mk("run3", 0,0,0,0,1, 32'h0,        32'hA3,
                         32'h110,      32'h10C,      32'hA3,  1,0,1));
        tbl.push_back(mk("stonly",0,0,0,1,1,32'h0,        32'hA4,
                         32'h110,      32'h10C,      32'hA3,  1,1,2));
        tbl.push_back(mk("pwonly",0,0,0,0,0,32'h0,        32'hA4,
                         32'h110,      32'h10C,      32'hA3,  1,1,3));
        tbl.push_back(mk("flst", 0,0,1,1,0, 32'h200,      32'hA4,
                         32'h200,      32'h0,        NOP,     0,3,3));
        tbl.push_back(mk("tgt",  0,0,0,0,1, 32'h0,        32'hB0,
                         32'h204,      32'h200,      32'hB0,  1,0,3));
        tbl.push_back(mk("memf0",0,1,1,0,1, 32'h300,      32'hB1,
                         32'h204,      32'h200,      32'hB0,  1,2,4));
        tbl.push_back(mk("memf1",0,1,1,0,1, 32'h300,      32'hB1,
                         32'h204,      32'h200,      32'hB0,  1,2,5));
        tbl.push_back(mk("memf2",0,1,1,0,1, 32'h300,      32'hB1,
                         32'h204,      32'h200,      32'hB0,  1,2,6));
        tbl.push_back(mk("memrel",0,0,1,0,1,32'h300,      32'hB1,
                         32'h300,      32'h0,        NOP,     0,3,6));
        tbl.push_back(mk("tgt2", 0,0,0,0,1, 32'h0,        32'hC0,
                         32'h304,      32'h300,      32'hC0,  1,0,6));
        tbl.push_back(mk("memlu",0,1,0,1,0, 32'h0,        32'hC1,
                         32'h304,      32'h300,      32'hC0,  1,2,7));
        tbl.push_back(mk("flhi", 0,0,1,0,1, 32'hFFFF_FFFC,32'hC1,
                         32'hFFFF_FFFC,32'h0,        NOP,     0,3,7));
        tbl.push_back(mk("wrap", 0,0,0,0,1, 32'h0,        32'hD0,
                         32'h0,        32'hFFFF_FFFC,32'hD0,  1,0,7));
        tbl.push_back(mk("rstmid",1,1,1,1,0,32'h500,      32'hD1,
                         32'h100,      32'h0,        NOP,     0,0,0));
        tbl.push_back(mk("run4", 0,0,0,0,1, 32'h0,        32'hE0,
                         32'h104,      32'h100,      32'hE0,  1,0,0));

        foreach (tbl[i]) apply(tbl[i]);

        // Long load-use hold: nothing moves for 4 edges, then advance.
        for (int k = 1; k <= 4; k++) begin
            apply(mk("luhold", 0,0,0,1,0, 32'h0, 32'hE1,
                     32'h104, 32'h100, 32'hE0, 1, 1, k));
        end
        apply(mk("lurel", 0,0,0,0,1, 32'h0, 32'hE1,
                 32'h108, 32'h104, 32'hE1, 1, 0, 4));

        // Two-cycle freeze over a flush, then redirect and target fetch.
        for (int k = 1; k <= 2; k++) begin
            apply(mk("memhold", 0,1,1,1,0, 32'h400, 32'hE2,
                     32'h108, 32'h104, 32'hE1, 1, 2, 4 + k));
        end
        apply(mk("redir", 0,0,1,0,1, 32'h400, 32'hE2,
                 32'h400, 32'h0, NOP, 0, 3, 6));
        apply(mk("fetch", 0,0,0,0,1, 32'h0, 32'hF0,
                 32'h404, 32'h400, 32'hF0, 1, 0, 6));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover %0d", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
